// File: rtl/program_memory_arbiter_if.sv
// Request/grant/response bus between fetch, debug and the program memory arbiter.
interface program_memory_arbiter_if #(parameter int DATA_WIDTH = 32);
  logic                  fetch_req_i, fetch_gnt_o, fetch_rvalid_o, fetch_err_o;
  logic [DATA_WIDTH-1:0] fetch_addr_i, fetch_rdata_o;
  logic                  dbg_req_i, dbg_lock_i, dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
  logic [DATA_WIDTH-1:0] dbg_addr_i, dbg_rdata_o;
  logic [DATA_WIDTH-1:0] mem_addr_o, mem_instr_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i, dbg_req_i, dbg_addr_i, dbg_lock_i, mem_instr_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
           dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o, mem_addr_o
  );
  modport master (
    output fetch_req_i, fetch_addr_i, dbg_req_i, dbg_addr_i, dbg_lock_i, mem_instr_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
           dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o, mem_addr_o
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// Fetch/debug arbiter for the single-port program memory: fetch priority,
// starvation counter for debug, registered one-cycle response with fault flag.
module pma_resp #(
  parameter int                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gnt,
  input  logic                  fault,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt) state_nx = RESP;
      RESP:    state_nx = gnt ? RESP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= NOP_WORD;
      err   <= 1'b0;
    end else if (gnt) begin
      rdata <= fault ? NOP_WORD : instr;
      err   <= fault;
    end
  end

  // Gated by reset so a reset right after a grant kills the pending response.
  assign rvalid = (state == RESP) && !reset;
endmodule

module program_memory_arbiter #(
  parameter int                    MEMORY_DEPTH = 256,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] PROGRAM_BASE = 32'h0040_0000,
  parameter int                    MAX_WAIT     = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0013
) (
  input logic                      clk,
  input logic                      reset,
  program_memory_arbiter_if.slave  bus
);
  localparam logic [3:0]          MAX_W = 4'(MAX_WAIT);
  localparam logic [DATA_WIDTH:0] UPPER = {1'b0, PROGRAM_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  logic [3:0]                 wait_cnt;
  logic                       starved, fault;
  logic [1:0]                 gnt, rvalid, err;
  logic [1:0][DATA_WIDTH-1:0] rdata;

  assign starved = bus.dbg_req_i && (wait_cnt == MAX_W);
  // Port 0 = fetch, port 1 = debug.
  assign gnt[1] = !reset && bus.dbg_req_i && (bus.dbg_lock_i || starved || !bus.fetch_req_i);
  assign gnt[0] = !reset && !bus.dbg_lock_i && bus.fetch_req_i && !starved;

  assign bus.mem_addr_o = gnt[1] ? bus.dbg_addr_i : bus.fetch_addr_i;
  assign fault = (bus.mem_addr_o[1:0] != 2'b00) || (bus.mem_addr_o < PROGRAM_BASE) ||
                 ({1'b0, bus.mem_addr_o} >= UPPER);

  always_ff @(posedge clk) begin
    if (reset || gnt[1] || !bus.dbg_req_i || bus.dbg_lock_i) wait_cnt <= '0;
    else if (gnt[0] && wait_cnt < MAX_W)                     wait_cnt <= wait_cnt + 4'd1;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    pma_resp #(.DATA_WIDTH(DATA_WIDTH), .NOP_WORD(NOP_WORD)) u_resp (
      .clk(clk), .reset(reset), .gnt(gnt[p]), .fault(fault), .instr(bus.mem_instr_i),
      .rvalid(rvalid[p]), .rdata(rdata[p]), .err(err[p])
    );
  end

  assign bus.fetch_gnt_o    = gnt[0];
  assign bus.fetch_rvalid_o = rvalid[0];
  assign bus.fetch_rdata_o  = rdata[0];
  assign bus.fetch_err_o    = err[0];
  assign bus.dbg_gnt_o      = gnt[1];
  assign bus.dbg_rvalid_o   = rvalid[1];
  assign bus.dbg_rdata_o    = rdata[1];
  assign bus.dbg_err_o      = err[1];
endmodule

// File: tb/tb_program_memory_arbiter.sv
// Table-driven bench with response scoreboard for program_memory_arbiter.
module tb_program_memory_arbiter;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] FA  = 32'h0040_0020;
  localparam logic [31:0] DA  = 32'h0040_0010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_memory_arbiter_if #(.DATA_WIDTH(32)) bus();
  program_memory_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        freq;  logic [31:0] faddr;
    logic        dreq;  logic [31:0] daddr;
    logic        lock;  logic [31:0] instr;
    logic        efg;   logic        edg;
    logic [31:0] emaddr; logic       eerr;
  } vec_t;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;

  vec_t  vecs[$];
  resp_t fq[$], dq[$];
  logic  fpend = 1'b0, dpend = 1'b0;
  int    n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_resp(input string nm);
    resp_t r;
    chk({nm, " fetch_rvalid"}, 32'(bus.fetch_rvalid_o), 32'(fpend));
    chk({nm, " dbg_rvalid"},   32'(bus.dbg_rvalid_o),   32'(dpend));
    if (fpend && fq.size() > 0) begin
      r = fq.pop_front();
      chk({nm, " fetch_rdata"}, bus.fetch_rdata_o, r.rdata);
      chk({nm, " fetch_err"},   32'(bus.fetch_err_o), 32'(r.err));
    end
    if (dpend && dq.size() > 0) begin
      r = dq.pop_front();
      chk({nm, " dbg_rdata"}, bus.dbg_rdata_o, r.rdata);
      chk({nm, " dbg_err"},   32'(bus.dbg_err_o), 32'(r.err));
    end
    fpend = 1'b0;
    dpend = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.fetch_req_i = v.freq; bus.fetch_addr_i = v.faddr;
    bus.dbg_req_i   = v.dreq; bus.dbg_addr_i   = v.daddr;
    bus.dbg_lock_i  = v.lock; bus.mem_instr_i  = v.instr;
  endtask

  task automatic step(input vec_t v, input int idx);
    string nm;
    resp_t r;
    nm = $sformatf("vec%0d", idx);
    drive(v);
    #2;
    chk({nm, " fetch_gnt"}, 32'(bus.fetch_gnt_o), 32'(v.efg));
    chk({nm, " dbg_gnt"},   32'(bus.dbg_gnt_o),   32'(v.edg));
    chk({nm, " mem_addr"},  bus.mem_addr_o, v.emaddr);
    r.rdata = v.eerr ? NOP : v.instr;
    r.err   = v.eerr;
    if (v.efg) fq.push_back(r);
    if (v.edg) dq.push_back(r);
    @(posedge clk); #1;
    fpend = v.efg;
    dpend = v.edg;
    check_resp(nm);
  endtask

  function automatic vec_t mk(logic fr, logic [31:0] fa, logic dr, logic [31:0] da, logic lk,
                              logic [31:0] in, logic fg, logic dg, logic [31:0] ma, logic er);
    vec_t v;
    v.freq = fr; v.faddr = fa; v.dreq = dr; v.daddr = da; v.lock = lk; v.instr = in;
    v.efg = fg; v.edg = dg; v.emaddr = ma; v.eerr = er;
    return v;
  endfunction

  initial begin
    // basic fetch and fault boundaries
    vecs.push_back(mk(1, 32'h0040_0008, 0, DA, 0, 32'h00A0_0513, 1, 0, 32'h0040_0008, 0));
    vecs.push_back(mk(1, 32'h0040_0006, 0, DA, 0, 32'h1111_1111, 1, 0, 32'h0040_0006, 1));
    vecs.push_back(mk(1, 32'h0040_0400, 0, DA, 0, 32'h1212_1212, 1, 0, 32'h0040_0400, 1));
    vecs.push_back(mk(1, 32'h0040_03FC, 0, DA, 0, 32'h2222_2222, 1, 0, 32'h0040_03FC, 0));
    vecs.push_back(mk(1, 32'h003F_FFFC, 0, DA, 0, 32'h2323_2323, 1, 0, 32'h003F_FFFC, 1));
    // starvation: four fetches, debug, then counter restarts from zero
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++)
        vecs.push_back(mk(1, FA, 1, DA, 0, 32'h3000_0000 + 32'(k*16 + j), 1, 0, FA, 0));
      vecs.push_back(mk(1, FA, 1, DA, 0, 32'h4000_0000 + 32'(k), 0, 1, DA, 0));
    end
    // alternating fetch then debug
    vecs.push_back(mk(1, FA, 0, DA, 0, 32'hAAAA_0001, 1, 0, FA, 0));
    vecs.push_back(mk(0, FA, 1, 32'h0040_0004, 0, 32'hBBBB_0002, 0, 1, 32'h0040_0004, 0));
    // debug lock
    vecs.push_back(mk(1, FA, 1, DA, 1, 32'h5555_0001, 0, 1, DA, 0));
    vecs.push_back(mk(1, FA, 1, DA, 1, 32'h5555_0002, 0, 1, DA, 0));
    vecs.push_back(mk(1, FA, 0, DA, 1, 32'h5555_0003, 0, 0, FA, 0));
    vecs.push_back(mk(1, FA, 1, DA, 0, 32'h5555_0004, 1, 0, FA, 0));
    // lock rises while the previous fetch response is in flight
    vecs.push_back(mk(1, FA, 1, DA, 1, 32'h6666_0001, 0, 1, DA, 0));
    vecs.push_back(mk(0, FA, 0, DA, 0, 32'h6666_0002, 0, 0, FA, 0));
    vecs.push_back(mk(0, FA, 1, 32'h0040_0401, 0, 32'h7777_0001, 0, 1, 32'h0040_0401, 1));

    // reset state, with both requests pending
    drive(mk(1, FA, 1, DA, 0, 32'hDEAD_BEEF, 0, 0, FA, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset fetch_gnt", 32'(bus.fetch_gnt_o), 32'd0);
    chk("reset dbg_gnt", 32'(bus.dbg_gnt_o), 32'd0);
    chk("reset fetch_rdata", bus.fetch_rdata_o, NOP);
    chk("reset dbg_rdata", bus.dbg_rdata_o, NOP);
    chk("reset fetch_err", 32'(bus.fetch_err_o), 32'd0);
    chk("reset dbg_err", 32'(bus.dbg_err_o), 32'd0);
    check_resp("reset");
    bus.fetch_req_i = 1'b0; bus.dbg_req_i = 1'b0;
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i], i);

    // reset in the cycle after a fetch grant suppresses that response
    drive(mk(1, 32'h0040_0008, 0, DA, 0, 32'h9999_9999, 1, 0, 32'h0040_0008, 0));
    #2;
    chk("rstgnt fetch_gnt", 32'(bus.fetch_gnt_o), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.fetch_req_i = 1'b0;
    #1;
    chk("rstgnt fetch_rvalid", 32'(bus.fetch_rvalid_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rstgnt fetch_rvalid after", 32'(bus.fetch_rvalid_o), 32'd0);
    chk("rstgnt fetch_rdata", bus.fetch_rdata_o, NOP);
    chk("rstgnt fetch_err", 32'(bus.fetch_err_o), 32'd0);
    chk("rstgnt queue empty", 32'(fq.size() + dq.size()), 32'd0);

    // counter must be back at zero after reset: fetch wins with debug pending
    step(mk(1, FA, 1, DA, 0, 32'hC0DE_0001, 1, 0, FA, 0), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/program_memory_arbiter.md
# program_memory_arbiter

Two-requester arbiter that shares the single combinational read port of the program memory between the CPU instruction-fetch path and a debug/boot read port. It grants at most one read per cycle, forwards the byte address to the memory, registers the returned word with one cycle of latency, and flags misaligned or out-of-range fetches. Fetch has priority, but a starvation counter guarantees debug forward progress. It sits between the PC/fetch stage, the debug unit and the program memory.

## Interface
- MEMORY_DEPTH, 256: program memory depth in 32-bit words.
- DATA_WIDTH, 32: address and instruction width.
- PROGRAM_BASE, 32'h0040_0000: byte address of word 0.
- MAX_WAIT, 4: cycles debug may wait while fetch wins before debug is forced through. Range is 1..15.
- NOP_WORD, 32'h0000_0013: word returned on a faulting access.
- clk  input  1  system clock. All state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_req_i  input  1  fetch read request. Held until granted.
- fetch_addr_i  input  DATA_WIDTH  fetch byte address. Stable while fetch_req_i is high.
- fetch_gnt_o  output  1  fetch granted this cycle (combinational).
- fetch_rvalid_o  output  1  one-cycle pulse: fetch_rdata_o/fetch_err_o valid.
- fetch_rdata_o  output  DATA_WIDTH  fetched instruction.
- fetch_err_o  output  1  granted fetch was misaligned or out of range.
- dbg_req_i  input  1  debug read request. Held until granted.
- dbg_addr_i  input  DATA_WIDTH  debug byte address.
- dbg_lock_i  input  1  CPU halted: fetch is never granted while high.
- dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o: debug counterparts of the four fetch outputs, same widths.
- mem_addr_o  output  DATA_WIDTH  byte address to program memory.
- mem_instr_i  input  DATA_WIDTH  instruction returned combinationally by program memory.

## Operation
- Grant logic, combinational from the requests, dbg_lock_i and wait_cnt:
  - If dbg_lock_i=1, grant debug if dbg_req_i=1. Fetch is never granted.
  - Else if dbg_req_i=1 and wait_cnt==MAX_WAIT, grant debug.
  - Else if fetch_req_i=1, grant fetch.
  - Else if dbg_req_i=1, grant debug.
  - Else no grant.
- mem_addr_o is the granted requester's address. With no grant it equals fetch_addr_i, so no bubble is added in the single-cycle path.
- Fault check on the granted address: fault = addr[1:0]!=0, or addr<PROGRAM_BASE, or addr ≥ PROGRAM_BASE+4*MEMORY_DEPTH. Compute the upper bound in 33 bits so it cannot wrap.
- Response register, loaded every clock:
  - Granted port: rvalid=1; rdata = fault ? NOP_WORD : mem_instr_i; err = fault.
  - Other port: rvalid=0; its rdata and err hold their previous values.
- wait_cnt, 4 bits:
  - Cleared when debug is granted, when dbg_req_i=0, or when dbg_lock_i=1.
  - Incremented, saturating at MAX_WAIT, when dbg_req_i=1 and fetch is granted.
- Response-state FSM, one per port: IDLE → RESP on a grant. RESP → RESP on a back-to-back grant, otherwise RESP → IDLE. rvalid is 1 exactly in RESP.
- Both ports may have responses in flight on consecutive cycles. Responses are never reordered, because each port has one outstanding access at most.

## Timing
- Grant in cycle N (gnt high, combinational). rvalid, rdata and err are valid in cycle N+1 and last one cycle.
- Throughput: one access per cycle total, and at most one per port per cycle.
- Worst-case debug latency with dbg_lock_i=0: MAX_WAIT+1 cycles from dbg_req_i rising to dbg_gnt_o.
- The requester drops req or changes addr in the cycle after gnt. A req still high after gnt is a new request.
- Reset (synchronous):
  - All rvalid and err outputs are 0.
  - fetch_rdata_o and dbg_rdata_o are NOP_WORD.
  - wait_cnt is 0 and both FSMs are IDLE.
  - gnt outputs are 0 while reset=1.
  - A reset in the cycle after a grant suppresses that response: no rvalid follows.
- dbg_lock_i rising in the same cycle as a fetch request: fetch is not granted. A fetch response already granted in the previous cycle still completes.

## Test plan
- Reset, then fetch_req_i=1, fetch_addr_i=0x0040_0008, mem_instr_i=0x00A00513 → fetch_gnt_o=1 the same cycle, mem_addr_o=0x0040_0008; next cycle fetch_rvalid_o=1, rdata=0x00A00513, err=0.
- Fetch at 0x0040_0006, then at 0x0040_0400 (DEPTH=256) → both give rvalid=1, err=1, rdata=0x0000_0013. Fetch at 0x0040_03FC → err=0.
- Fetch held high and dbg_req_i=1 continuously with MAX_WAIT=4 → fetch granted on 4 consecutive cycles, debug on the 5th, then fetch again. wait_cnt returns to 0 after the debug grant.
- dbg_lock_i=1 with both requests high → only dbg_gnt_o asserts, every cycle. fetch_gnt_o stays 0 until the lock drops, then fetch is granted in that cycle.
- Alternating grants (fetch in N, debug in N+1) → fetch_rvalid_o in N+1, dbg_rvalid_o in N+2, each carrying its own mem_instr_i sample.
- Reset asserted in the cycle after a fetch grant → no fetch_rvalid_o pulse, and outputs take their reset values.
